// File: rtl/lossless_decoder.sv
// Lossless bitstream decoder: unpacks prefix-coded coefficients from SRAM,
// dequantises them and writes them back in zigzag-to-raster order.
module lossless_decoder #(
  parameter logic [17:0] IN_BASE    = 18'd0,
  parameter logic [17:0] OUT_BASE   = 18'd76800,
  parameter logic [11:0] NUM_BLOCKS = 12'd2400
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        M3_start,
  output logic        M3_end,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [15:0] SRAM_write_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_DECODE,
    S_RUN,
    S_EOB,
    S_DONE
  } state_t;

  // Raster position (8*r + c) of each scan index
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_t      state;
  logic        start_q;
  logic [31:0] bit_buf;
  logic [5:0]  valid;
  logic [17:0] rd_ptr;
  logic [2:0]  rd_pipe;
  logic [5:0]  k;
  logic [11:0] block;
  logic [3:0]  run_left;

  logic        in_flight;
  logic        refill;
  logic        can_decode;
  logic [1:0]  prefix;
  logic        write_coef;
  logic        write_zero;
  logic        do_write;
  logic [5:0]  pos;
  logic [3:0]  diag;
  logic [2:0]  q;
  logic [15:0] coef_ext;
  logic [15:0] coef;
  logic [17:0] wr_addr;
  logic        last_coef;
  logic [11:0] block_inc;
  logic        blocks_done;
  logic [5:0]  consume;
  logic [31:0] shifted;
  logic [5:0]  valid_left;
  logic [31:0] buf_next;
  logic [5:0]  valid_next;

  assign in_flight  = |rd_pipe;
  // A refill read owns the bus; decode and zero writes yield for that cycle
  assign refill     = (state inside {S_PREFETCH, S_DECODE, S_RUN, S_EOB}) &&
                      (valid <= 6'd16) && !in_flight;
  assign can_decode = (state == S_DECODE) && !refill && (valid >= 6'd9);
  assign prefix     = bit_buf[31:30];
  assign write_coef = can_decode && !prefix[1];
  assign write_zero = ((state == S_RUN) || (state == S_EOB)) && !refill;
  assign do_write   = write_coef || write_zero;

  assign pos         = ZIGZAG[k];
  assign diag        = {1'b0, pos[5:3]} + {1'b0, pos[2:0]};
  assign wr_addr     = OUT_BASE + {block, 6'b0} + {12'b0, pos};
  assign last_coef   = (k == 6'd63);
  assign block_inc   = block + 12'd1;
  assign blocks_done = (block_inc == NUM_BLOCKS);

  always_comb begin
    q = 3'd5;
    if (diag == 4'd0)
      q = 3'd3;
    else if (diag <= 4'd3)
      q = 3'd2;
    else if (diag <= 4'd7)
      q = 3'd3;
    else if (diag <= 4'd11)
      q = 3'd4;
  end

  always_comb begin
    coef_ext = '0;
    if (write_coef) begin
      if (prefix == 2'b00)
        coef_ext = {{13{bit_buf[29]}}, bit_buf[29:27]};
      else
        coef_ext = {{10{bit_buf[29]}}, bit_buf[29:24]};
    end
    coef = coef_ext << q;
  end

  // Consumed bits leave from the top; an arriving word lands just below what remains
  always_comb begin
    consume = '0;
    if (can_decode) begin
      case (prefix)
        2'b00:   consume = 6'd5;
        2'b01:   consume = 6'd8;
        2'b10:   consume = 6'd5;
        default: consume = 6'd2;
      endcase
    end
    shifted    = bit_buf << consume;
    valid_left = valid - consume;
    buf_next   = shifted;
    valid_next = valid_left;
    if (rd_pipe[2]) begin
      buf_next   = shifted | ({SRAM_read_data, 16'h0000} >> valid_left);
      valid_next = valid_left + 6'd16;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      start_q         <= 1'b0;
      bit_buf         <= '0;
      valid           <= '0;
      rd_ptr          <= '0;
      rd_pipe         <= '0;
      k               <= '0;
      block           <= '0;
      run_left        <= '0;
      M3_end          <= 1'b0;
      SRAM_address    <= '0;
      SRAM_we_n       <= 1'b1;
      SRAM_write_data <= '0;
    end else begin
      start_q   <= M3_start;
      M3_end    <= 1'b0;
      SRAM_we_n <= 1'b1;
      rd_pipe   <= {rd_pipe[1:0], refill};
      bit_buf   <= buf_next;
      valid     <= valid_next;

      if (refill) begin
        SRAM_address <= rd_ptr;
        rd_ptr       <= rd_ptr + 18'd1;
      end else if (do_write) begin
        SRAM_address    <= wr_addr;
        SRAM_write_data <= coef;
        SRAM_we_n       <= 1'b0;
        k               <= k + 6'd1;
        if (last_coef)
          block <= block_inc;
      end

      case (state)
        S_IDLE: begin
          if (M3_start && !start_q) begin
            state   <= S_PREFETCH;
            rd_ptr  <= IN_BASE;
            k       <= '0;
            block   <= '0;
            bit_buf <= '0;
            valid   <= '0;
          end
        end
        S_PREFETCH: begin
          if (valid == 6'd32)
            state <= S_DECODE;
        end
        S_DECODE: begin
          if (can_decode) begin
            case (prefix)
              2'b10: begin
                run_left <= (bit_buf[29:27] == 3'd0) ? 4'd8 : {1'b0, bit_buf[29:27]};
                state    <= S_RUN;
              end
              2'b11: state <= S_EOB;
              default: begin
                if (last_coef && blocks_done)
                  state <= S_DONE;
              end
            endcase
          end
        end
        S_RUN: begin
          if (write_zero) begin
            run_left <= run_left - 4'd1;
            // A run reaching the block end is cut short; leftover zeros are dropped
            if (last_coef)
              state <= blocks_done ? S_DONE : S_DECODE;
            else if (run_left == 4'd1)
              state <= S_DECODE;
          end
        end
        S_EOB: begin
          if (write_zero && last_coef)
            state <= blocks_done ? S_DONE : S_DECODE;
        end
        S_DONE: begin
          if (!in_flight) begin
            M3_end  <= 1'b1;
            state   <= S_IDLE;
            bit_buf <= '0;
            valid   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
